// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory responder for a multicycle RISC-V core. It accepts one fetch, load
//   or store at a time, serves it from an internal word-addressed RAM after a
//   configurable number of wait states, and pulses done (with err on a bad
//   request) when it finishes.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   if_en      1 = instruction fetch, 0 = data access
//   fetch_en   request strobe, sampled only while idle
//   bytesel    {unsigned, size[1:0]}; size 00 byte, 01 half, 10 word, 11 reserved
//   mem_write  1 = store, 0 = load (ignored for fetches)
//   addr       byte address
//   wdata      store data, right-aligned
//   busy       request in progress
//   done       one-cycle completion pulse
//   err        qualifies done: misaligned, out of range or reserved size
//   rdata      extended load result, held until the next good load
//   instr      fetched instruction, held until the next good fetch
module mem_access_unit #(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_en,
  input  logic        fetch_en,
  input  logic [2:0]  bytesel,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] instr
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;

  logic        req_if_p0;
  logic [2:0]  req_bsel_p0;
  logic        req_wr_p0;
  logic [31:0] req_addr_p0;
  logic [31:0] req_wdata_p0;

  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic          do_write;

  logic [31:0] mem [MEM_WORDS];

  // Sized, lane-selected load result with sign or zero extension.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  bsel,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[lane*8 +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (bsel[1:0])
      2'b00:   res = bsel[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = bsel[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Read-modify-write merge: replicate the store data across lanes, then
  // take only the enabled byte lanes from it.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [3:0]  be;
    logic [31:0] rep;
    logic [31:0] res;
    case (size)
      2'b00: begin
        be  = 4'b0001 << lane;
        rep = {4{wd[7:0]}};
      end
      2'b01: begin
        be  = lane[1] ? 4'b1100 : 4'b0011;
        rep = {2{wd[15:0]}};
      end
      default: begin
        be  = 4'b1111;
        rep = wd;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? rep[i*8 +: 8] : old[i*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    req_err = 1'b0;
    if (req_if_p0) begin
      req_err = (req_addr_p0[1:0] != 2'b00);
    end else begin
      case (req_bsel_p0[1:0])
        2'b00:   req_err = 1'b0;
        2'b01:   req_err = req_addr_p0[0];
        2'b10:   req_err = (req_addr_p0[1:0] != 2'b00);
        default: req_err = 1'b1;
      endcase
    end
    if (req_addr_p0[31:2] >= 30'(MEM_WORDS)) begin
      req_err = 1'b1;
    end
  end

  assign word_idx = req_addr_p0[AW+1:2];
  assign rd_word  = mem[word_idx];
  assign do_write = (state == S_ACCESS) && !req_if_p0 && req_wr_p0 && !req_err;
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (fetch_en) begin
          if (WAIT_STATES > 0) begin
            state_nx = S_WAIT;
            cnt_nx   = 4'(WAIT_STATES - 1);
          end else begin
            state_nx = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = S_ACCESS;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_ACCESS: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
      instr <= RESET_INSTR;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= (state == S_ACCESS);
      err   <= (state == S_ACCESS) && req_err;
      if ((state == S_ACCESS) && !req_err) begin
        if (req_if_p0) begin
          instr <= rd_word;
        end else if (!req_wr_p0) begin
          rdata <= load_extend(rd_word, req_bsel_p0, req_addr_p0[1:0]);
        end
      end
    end
  end

  // Request capture: only the accept edge loads these, so inputs are
  // ignored for the rest of the transaction.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && fetch_en) begin
      req_if_p0    <= if_en;
      req_bsel_p0  <= bytesel;
      req_wr_p0    <= mem_write;
      req_addr_p0  <= addr;
      req_wdata_p0 <= wdata;
    end
  end

  // RAM write; a reset in the access cycle cancels the store.
  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      mem[word_idx] <= store_merge(rd_word, req_wdata_p0, req_bsel_p0[1:0],
                                   req_addr_p0[1:0]);
    end
  end

endmodule
